instr_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM-subset pipeline.
- Owns the PC and drives the address into the combinational instruction memory, which returns the word in the same cycle.
- Registers the returned word into the IF/ID pipeline register and handles decode stalls and execute-stage branch redirects by squashing the wrong-path fetch into NOP bubbles.
- Keeps a retired-fetch counter for the Fibonacci benchmark bring-up.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/instr_fetch_unit_if.sv | 19 +
 rtl/if_id_reg.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the ARM-subset core.
// Imported by fetch, the IF/ID register and the instruction memory.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0800_0000;
    localparam logic [XLEN-1:0] PC_READ_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_BUBBLE
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus8;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port: fetch drives the address,
// memory answers combinationally in the same cycle.
interface instr_fetch_unit_if;
    import pipeline_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// Enable/flush pipeline register for instr, pc, pc+8, valid.
// Flush wins over enable and turns the slot into a bubble.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t slot_q;
    if_id_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.instr = NOP;
            slot_d.valid = 1'b0;
        end else if (en) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q.instr    <= NOP;
            slot_q.pc       <= '0;
            slot_q.pc_plus8 <= PC_READ_OFFSET;
            slot_q.valid    <= 1'b0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches from combinational imem and
// feeds IF/ID, squashing wrong-path slots after a redirect.
module instr_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    instr_fetch_unit_if.master imem,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    output logic        flush_d,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] BUB_LOAD = 2'(REDIRECT_BUBBLES - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [1:0]   bub_q, bub_d;
    logic [31:0]  count_q, count_d;
    logic         reg_en;
    logic         reg_flush;
    if_id_t       fetch_slot;
    if_id_t       ifid;

    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        bub_d     = bub_q;
        count_d   = count_q;
        reg_en    = 1'b0;
        reg_flush = 1'b0;
        unique case (state_q)
            S_START: state_d = S_RUN;
            S_RUN, S_BUBBLE: begin
                if (branch_taken_e) begin
                    pc_f_d    = word_align(branch_target_e);
                    reg_flush = 1'b1;
                    bub_d     = BUB_LOAD;
                    state_d   = (BUB_LOAD == 2'd0) ? S_RUN
                                                   : S_BUBBLE;
                end else if (state_q == S_BUBBLE) begin
                    // leave once the last inserted bubble is in IF/ID
                    reg_flush = 1'b1;
                    bub_d     = bub_q - 2'd1;
                    if (bub_q <= 2'd1) state_d = S_RUN;
                end else if (!stall_f) begin
                    reg_en  = 1'b1;
                    pc_f_d  = pc_f_q + 32'd4;
                    count_d = count_q + 32'd1;
                end
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_START;
            pc_f_q  <= RESET_PC;
            bub_q   <= 2'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
            bub_q   <= bub_d;
            count_q <= count_d;
        end
    end

    assign imem.imem_addr = word_align(pc_f_q);

    assign fetch_slot.instr    = imem.imem_rdata;
    assign fetch_slot.pc       = pc_f_q;
    assign fetch_slot.pc_plus8 = pc_f_q + PC_READ_OFFSET;
    assign fetch_slot.valid    = 1'b1;

    if_id_reg #(
        .NOP (NOP_WORD)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (reg_en),
        .flush (reg_flush),
        .d_i   (fetch_slot),
        .q_o   (ifid)
    );

    assign instr_d     = ifid.instr;
    assign pc_d        = ifid.pc;
    assign pc_plus8_d  = ifid.pc_plus8;
    assign valid_d     = ifid.valid;
    assign fetch_count = count_q;
    assign flush_d     = branch_taken_e && (state_q != S_START);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random + directed bench: two fetch units (1 and 3 redirect
// bubbles) share stimulus and are checked against a cycle model.
module tb_instr_fetch_unit;
    import pipeline_pkg::*;

    localparam int MEM_WORDS = 64;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        branch_taken_e;
    logic [31:0] branch_target_e;

    logic [31:0] instr_o   [2];
    logic [31:0] pc_d_o    [2];
    logic [31:0] p8_o      [2];
    logic        valid_o   [2];
    logic        flush_o   [2];
    logic [31:0] count_o   [2];
    logic [31:0] addr_o    [2];

    logic [31:0] mem [MEM_WORDS];

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    assign bus0.imem_rdata = (bus0.imem_addr[31:2] < 30'd64)
                           ? mem[bus0.imem_addr[7:2]] : NOP_WORD;
    assign bus1.imem_rdata = (bus1.imem_addr[31:2] < 30'd64)
                           ? mem[bus1.imem_addr[7:2]] : NOP_WORD;
    assign addr_o[0] = bus0.imem_addr;
    assign addr_o[1] = bus1.imem_addr;

    instr_fetch_unit #(
        .REDIRECT_BUBBLES (1)
    ) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .stall_f         (stall_f),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .imem            (bus0),
        .instr_d         (instr_o[0]),
        .pc_d            (pc_d_o[0]),
        .pc_plus8_d      (p8_o[0]),
        .valid_d         (valid_o[0]),
        .flush_d         (flush_o[0]),
        .fetch_count     (count_o[0])
    );

    instr_fetch_unit #(
        .REDIRECT_BUBBLES (3)
    ) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .stall_f         (stall_f),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .imem            (bus1),
        .instr_d         (instr_o[1]),
        .pc_d            (pc_d_o[1]),
        .pc_plus8_d      (p8_o[1]),
        .valid_d         (valid_o[1]),
        .flush_d         (flush_o[1]),
        .fetch_count     (count_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit primed  = 0;

    // reference state, one entry per DUT
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pcd   [2];
    logic [31:0] m_p8    [2];
    logic [31:0] m_cnt   [2];
    logic        m_v     [2];
    logic        m_run   [2];
    int          m_left  [2];
    int          rb      [2] = '{1, 3};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (w < MEM_WORDS) return mem[w];
        return NOP_WORD;
    endfunction

    task automatic model_step(input int k, input logic rst,
                              input logic st, input logic br,
                              input logic [31:0] tgt);
        if (rst) begin
            m_pc[k] = 32'd0;    m_instr[k] = NOP_WORD;
            m_pcd[k] = 32'd0;   m_p8[k] = 32'd8;
            m_v[k] = 1'b0;      m_cnt[k] = 32'd0;
            m_run[k] = 1'b0;    m_left[k] = 0;
        end else if (!m_run[k]) begin
            m_run[k] = 1'b1;
        end else if (br) begin
            m_pc[k]    = tgt & 32'hFFFF_FFFC;
            m_instr[k] = NOP_WORD;
            m_v[k]     = 1'b0;
            m_left[k]  = rb[k] - 1;
        end else if (m_left[k] > 0) begin
            m_instr[k] = NOP_WORD;
            m_v[k]     = 1'b0;
            m_left[k]  = m_left[k] - 1;
        end else if (!st) begin
            m_instr[k] = mem_word(m_pc[k]);
            m_pcd[k]   = m_pc[k];
            m_p8[k]    = m_pc[k] + 32'd8;
            m_v[k]     = 1'b1;
            m_cnt[k]   = m_cnt[k] + 32'd1;
            m_pc[k]    = m_pc[k] + 32'd4;
        end
    endtask

    task automatic step(input logic rst, input logic st,
                        input logic br, input logic [31:0] tgt);
        @(negedge clk);
        reset           = rst;
        stall_f         = st;
        branch_taken_e  = br;
        branch_target_e = tgt;
        #1;
        if (primed) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("imem_addr%0d", k),
                      addr_o[k], m_pc[k]);
                if (!rst)
                    check($sformatf("flush_d%0d", k),
                          {31'd0, flush_o[k]},
                          {31'd0, br && m_run[k]});
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, rst, st, br, tgt);
        #1;
        primed = 1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("instr_d%0d", k), instr_o[k], m_instr[k]);
            check($sformatf("pc_d%0d", k), pc_d_o[k], m_pcd[k]);
            check($sformatf("pc_plus8_d%0d", k), p8_o[k], m_p8[k]);
            check($sformatf("valid_d%0d", k),
                  {31'd0, valid_o[k]}, {31'd0, m_v[k]});
            check($sformatf("fetch_count%0d", k),
                  count_o[k], m_cnt[k]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, s, b;
        logic [31:0] t;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'hEF20_000C;
        mem[1] = 32'hEF20_1000;
        mem[5] = 32'hE801_3002;
        reset = 1'b1;
        stall_f = 1'b0;
        branch_taken_e = 1'b0;
        branch_target_e = 32'd0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_addr", addr_o[0], 32'd0);
        check("rst_instr", instr_o[0], 32'h0800_0000);
        check("rst_p8", p8_o[0], 32'd8);

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("first_instr", instr_o[0], 32'hEF20_000C);
        step(0, 0, 0, 0);
        check("second_instr", instr_o[0], 32'hEF20_1000);
        check("count2", count_o[0], 32'd2);

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("stall_addr", addr_o[0], 32'd8);
        check("stall_count", count_o[0], 32'd2);
        step(0, 0, 0, 0);
        check("release_pc_d", pc_d_o[0], 32'd8);

        for (int i = 0; i < 20 && m_pc[0] != 32'h28; i++)
            step(0, 0, 0, 0);
        check("pre_branch_addr", addr_o[0], 32'h28);
        step(0, 0, 1, 32'h14);
        check("redir_addr", addr_o[0], 32'h14);
        check("redir_valid", {31'd0, valid_o[0]}, 32'd0);
        step(0, 0, 0, 0);
        check("target_instr", instr_o[0], 32'hE801_3002);
        check("target_pc_d", pc_d_o[0], 32'h14);
        check("target_p8", p8_o[0], 32'h1C);

        step(0, 1, 1, 32'h17);
        check("br_over_stall", addr_o[0], 32'h14);

        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap_addr", addr_o[0], 32'd0);
        check("wrap_p8", p8_o[0], 32'd4);

        step(0, 0, 1, 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h80);
        check("rebr_v0", {31'd0, valid_o[1]}, 32'd0);
        step(0, 0, 0, 0);
        check("rebr_v1", {31'd0, valid_o[1]}, 32'd0);
        step(0, 0, 0, 0);
        check("rebr_v2", {31'd0, valid_o[1]}, 32'd0);
        step(0, 0, 0, 0);
        check("rebr_v3", {31'd0, valid_o[1]}, 32'd1);
        check("rebr_pc_d", pc_d_o[1], 32'h80);

        step(0, 0, 1, 32'h40);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("midbub_addr", addr_o[1], 32'd0);
        check("midbub_count", count_o[1], 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 9) == 0)
                t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                t = 32'($urandom_range(0, 80) * 4
                        + $urandom_range(0, 3));
            step(r, s, b, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
